// File: rtl/msxbus_pkg.sv
// Shared definitions for the MSX slot bus engines: T-state encodings, default divider
// and the strobe decode used by the initiator.
package msxbus_pkg;

  localparam int unsigned MSXBUS_CLK_DIV = 24;
  localparam logic        STROBE_OFF     = 1'b1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_T1   = 3'd1;
  localparam logic [2:0] ST_T2   = 3'd2;
  localparam logic [2:0] ST_TW   = 3'd3;
  localparam logic [2:0] ST_T3   = 3'd4;

  typedef struct packed {
    logic n_sltsl;
    logic n_mereq;
    logic n_ioreq;
    logic n_rd;
    logic n_wr;
    logic is_output;
  } strobes_t;

  // Pin levels for a given T-state; first_half means tcnt < CLK_DIV/2.
  function automatic strobes_t decode_strobes(input logic [2:0] st, input logic first_half,
                                              input logic io, input logic wr);
    logic in_t1, in_t2, in_tw, in_t3;
    logic win_mem, win_io, win_mwr, rd_win, wr_win;
    strobes_t s;
    in_t1   = (st == ST_T1);
    in_t2   = (st == ST_T2);
    in_tw   = (st == ST_TW);
    in_t3   = (st == ST_T3);
    win_mem = (in_t1 && !first_half) || in_t2 || in_tw || (in_t3 && first_half);
    win_io  = in_t2 || in_tw || (in_t3 && first_half);
    win_mwr = (in_t2 && !first_half) || in_tw || (in_t3 && first_half);
    rd_win  = !wr && (io ? win_io : win_mem);
    wr_win  = wr && (io ? win_io : win_mwr);
    s.n_sltsl   = STROBE_OFF ^ (!io && win_mem);
    s.n_mereq   = STROBE_OFF ^ (!io && win_mem);
    s.n_ioreq   = STROBE_OFF ^ (io && win_io);
    s.n_rd      = STROBE_OFF ^ rd_win;
    s.n_wr      = STROBE_OFF ^ wr_win;
    s.is_output = wr && ((in_t1 && !first_half) || in_t2 || in_tw || in_t3);
    return s;
  endfunction

endpackage

// File: rtl/ip_msxbus_master_tstate.sv
// T-state divider: counts 0..CLK_DIV-1 while a bus cycle runs, held at 0 otherwise.
module ip_msxbus_master_tstate
  import msxbus_pkg::*;
#(
  parameter int unsigned CLK_DIV = MSXBUS_CLK_DIV
) (
  input  logic                       clk,
  input  logic                       n_reset,
  input  logic                       run,
  input  logic                       restart,
  output logic [$clog2(CLK_DIV)-1:0] tcnt,
  output logic                       t_last,
  output logic                       t_half
);

  localparam int unsigned         TCNT_W = $clog2(CLK_DIV);
  localparam logic [TCNT_W-1:0]   LAST   = TCNT_W'(CLK_DIV - 1);
  localparam logic [TCNT_W-1:0]   HALF   = TCNT_W'(CLK_DIV / 2);

  logic [TCNT_W-1:0] tcnt_q, tcnt_d;

  always_comb begin
    tcnt_d = tcnt_q + 1'b1;
    if (restart || !run || (tcnt_q == LAST)) begin
      tcnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end

  assign tcnt   = tcnt_q;
  assign t_last = (tcnt_q == LAST);
  assign t_half = (tcnt_q == HALF);

endmodule

// File: rtl/ip_msxbus_master.sv
// ip_msxbus_master: turns single internal requests into Z80-timed MSX slot bus cycles.
// Define MSXBUS_MASTER_WAIT_EN to synchronise n_wait and insert wait states on demand.
module ip_msxbus_master
  import msxbus_pkg::*;
#(
  parameter int unsigned CLK_DIV = MSXBUS_CLK_DIV
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] bus_address,
  input  logic [7:0]  bus_write_data,
  input  logic        bus_io_req,
  input  logic        bus_memory_req,
  input  logic        bus_write,
  output logic        bus_ack,
  output logic [7:0]  bus_read_data,
  output logic        bus_read_data_en,
  output logic [15:0] adr,
  output logic [7:0]  o_data,
  input  logic [7:0]  i_data,
  output logic        is_output,
  output logic        n_sltsl,
  output logic        n_mereq,
  output logic        n_ioreq,
  output logic        n_rd,
  output logic        n_wr,
  input  logic        n_wait
);

  localparam int unsigned       TCNT_W = $clog2(CLK_DIV);
  localparam logic [TCNT_W-1:0] HALF   = TCNT_W'(CLK_DIV / 2);

  logic [2:0]        state_q, state_d;
  logic              io_q, wr_q;
  logic [15:0]       adr_q;
  logic [7:0]        odata_q, rdata_q;
  logic              ack_q, rden_q;
  logic              accept, wait_act, cycle_done;
  logic [TCNT_W-1:0] tcnt;
  logic              t_last, t_half;
  strobes_t          strb;

  // The T3->IDLE edge never accepts, so every cycle is followed by one IDLE clock.
  assign accept     = (state_q == ST_IDLE) && (bus_io_req || bus_memory_req);
  assign cycle_done = (state_q == ST_T3) && t_last;

  ip_msxbus_master_tstate #(.CLK_DIV(CLK_DIV)) u_tstate (
    .clk     (clk),
    .n_reset (n_reset),
    .run     (state_q != ST_IDLE),
    .restart (accept),
    .tcnt    (tcnt),
    .t_last  (t_last),
    .t_half  (t_half)
  );

`ifdef MSXBUS_MASTER_WAIT_EN
  logic [1:0] wait_sync_q;
  logic       wait_pend_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wait_sync_q <= 2'b11;
      wait_pend_q <= 1'b0;
    end else begin
      wait_sync_q <= {wait_sync_q[0], n_wait};
      if (t_half && ((state_q == ST_T2) || (state_q == ST_TW))) begin
        wait_pend_q <= ~wait_sync_q[1];
      end
    end
  end

  assign wait_act = wait_pend_q;
`else
  logic unused_n_wait;
  assign unused_n_wait = n_wait;
  assign wait_act      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_T1;
      ST_T1:   if (t_last) state_d = ST_T2;
      ST_T2:   if (t_last) state_d = (io_q || wait_act) ? ST_TW : ST_T3;
      ST_TW:   if (t_last) state_d = wait_act ? ST_TW : ST_T3;
      ST_T3:   if (t_last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= ST_IDLE;
      io_q    <= 1'b0;
      wr_q    <= 1'b0;
      adr_q   <= '0;
      odata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      rden_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= cycle_done;
      rden_q  <= cycle_done && !wr_q;
      if (accept) begin
        io_q    <= bus_io_req;
        wr_q    <= bus_write;
        adr_q   <= bus_address;
        odata_q <= bus_write_data;
      end
      if ((state_q == ST_T3) && t_half && !wr_q) begin
        rdata_q <= i_data;
      end
    end
  end

  assign strb = decode_strobes(state_q, (tcnt < HALF), io_q, wr_q);

  assign n_sltsl          = strb.n_sltsl;
  assign n_mereq          = strb.n_mereq;
  assign n_ioreq          = strb.n_ioreq;
  assign n_rd             = strb.n_rd;
  assign n_wr             = strb.n_wr;
  assign is_output        = strb.is_output;
  assign adr              = adr_q;
  assign o_data           = odata_q;
  assign bus_ack          = ack_q;
  assign bus_read_data    = rdata_q;
  assign bus_read_data_en = rden_q;

endmodule

// File: tb/tb_ip_msxbus_master.sv
// Directed bench for ip_msxbus_master: cycle timing, strobe windows, arbitration,
// reset abort and back-to-back throughput with hand-computed expectations.
module tb_ip_msxbus_master;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [15:0] bus_address;
  logic [7:0]  bus_write_data;
  logic        bus_io_req, bus_memory_req, bus_write;
  logic        bus_ack, bus_read_data_en, is_output;
  logic [7:0]  bus_read_data, o_data, i_data;
  logic [15:0] adr;
  logic        n_sltsl, n_mereq, n_ioreq, n_rd, n_wr, n_wait;

  always #5 clk = ~clk;

  ip_msxbus_master dut (
    .clk              (clk),
    .n_reset          (n_reset),
    .bus_address      (bus_address),
    .bus_write_data   (bus_write_data),
    .bus_io_req       (bus_io_req),
    .bus_memory_req   (bus_memory_req),
    .bus_write        (bus_write),
    .bus_ack          (bus_ack),
    .bus_read_data    (bus_read_data),
    .bus_read_data_en (bus_read_data_en),
    .adr              (adr),
    .o_data           (o_data),
    .i_data           (i_data),
    .is_output        (is_output),
    .n_sltsl          (n_sltsl),
    .n_mereq          (n_mereq),
    .n_ioreq          (n_ioreq),
    .n_rd             (n_rd),
    .n_wr             (n_wr),
    .n_wait           (n_wait)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-transaction observations (index k = samples after the k-th edge from acceptance).
  int          lat, first_low, ack_cyc;
  int          c_mereq, c_ioreq, c_rd, c_wr, c_sltsl, c_isout, c_rden, odata_bad;
  logic        rden_at_ack;
  logic [15:0] adr_t1;

  task automatic run_cycle(input bit io_r, input bit mem_r, input bit wr,
                           input logic [15:0] addr, input logic [7:0] wdata,
                           input logic [7:0] rdin, input int wait_start, input bit hold);
    bus_io_req = io_r; bus_memory_req = mem_r; bus_write = wr;
    bus_address = addr; bus_write_data = wdata; i_data = rdin;
    lat = -1; first_low = -1; rden_at_ack = 1'b0; adr_t1 = 16'hxxxx;
    c_mereq = 0; c_ioreq = 0; c_rd = 0; c_wr = 0; c_sltsl = 0;
    c_isout = 0; c_rden = 0; odata_bad = 0;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      if (k == 0) adr_t1 = adr;
      if (wait_start >= 0 && k == wait_start)      n_wait = 1'b0;
      if (wait_start >= 0 && k == wait_start + 30) n_wait = 1'b1;
      if (!n_mereq) c_mereq++;
      if (!n_ioreq) c_ioreq++;
      if (!n_rd)    c_rd++;
      if (!n_wr)    c_wr++;
      if (!n_sltsl) c_sltsl++;
      if (first_low < 0 && (!n_mereq || !n_ioreq || !n_rd || !n_wr || !n_sltsl)) first_low = k;
      if (is_output) begin
        c_isout++;
        if (o_data !== wdata) odata_bad++;
      end
      if (bus_read_data_en) c_rden++;
      if (bus_ack) begin
        lat = k; ack_cyc = cyc; rden_at_ack = bus_read_data_en;
        break;
      end
    end
    if (!hold || lat < 0) begin
      bus_io_req = 1'b0; bus_memory_req = 1'b0;
    end
    n_wait = 1'b1;
  endtask

  task automatic idle_gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int prev_ack, acks;
  int exp_wait_lat, exp_wait_wr, exp_wait_mreq;

  initial begin
    n_reset = 1'b0; bus_address = '0; bus_write_data = '0; bus_io_req = 1'b0;
    bus_memory_req = 1'b0; bus_write = 1'b0; i_data = '0; n_wait = 1'b1;
`ifdef MSXBUS_MASTER_WAIT_EN
    exp_wait_lat = 120; exp_wait_wr = 72; exp_wait_mreq = 96;
`else
    exp_wait_lat = 72;  exp_wait_wr = 24; exp_wait_mreq = 48;
`endif

    // Reset state
    idle_gap(3);
    check_eq("rst_strobes", {n_sltsl, n_mereq, n_ioreq, n_rd, n_wr}, 5'b11111);
    check_eq("rst_is_output", is_output, 1'b0);
    check_eq("rst_ack", {bus_ack, bus_read_data_en}, 2'b00);
    check_eq("rst_adr", adr, 16'h0000);
    check_eq("rst_odata", o_data, 8'h00);
    check_eq("rst_rdata", bus_read_data, 8'h00);
    @(negedge clk) n_reset = 1'b1;
    idle_gap(3);

    // Memory read 0x4000 <- 0xA5
    run_cycle(1'b0, 1'b1, 1'b0, 16'h4000, 8'h00, 8'hA5, -1, 1'b0);
    $display("[TB] mem rd 4000: lat=%0d mereq=%0d rd=%0d first=%0d data=%02h", lat, c_mereq, c_rd, first_low, bus_read_data);
    check_eq("mrd_lat", lat, 72);
    check_eq("mrd_mereq", c_mereq, 48);
    check_eq("mrd_rd", c_rd, 48);
    check_eq("mrd_sltsl", c_sltsl, 48);
    check_eq("mrd_first", first_low, 12);
    check_eq("mrd_wr_io", c_wr + c_ioreq + c_isout, 0);
    check_eq("mrd_rden", {rden_at_ack, 8'(c_rden)}, {1'b1, 8'd1});
    check_eq("mrd_data", bus_read_data, 8'hA5);
    check_eq("mrd_adr", adr, 16'h4000);
    idle_gap(1);
    check_eq("mrd_ack_pulse", {bus_ack, bus_read_data_en}, 2'b00);
    idle_gap(3);

    // I/O write 0x98 <- 0x3C
    run_cycle(1'b1, 1'b0, 1'b1, 16'h0098, 8'h3C, 8'h00, -1, 1'b0);
    $display("[TB] io wr 98: lat=%0d ioreq=%0d wr=%0d first=%0d isout=%0d", lat, c_ioreq, c_wr, first_low, c_isout);
    check_eq("iow_lat", lat, 96);
    check_eq("iow_ioreq", c_ioreq, 60);
    check_eq("iow_wr", c_wr, 60);
    check_eq("iow_first", first_low, 24);
    check_eq("iow_mem_rd", c_mereq + c_sltsl + c_rd, 0);
    check_eq("iow_isout", c_isout, 84);
    check_eq("iow_odata", odata_bad, 0);
    check_eq("iow_rden", c_rden, 0);
    check_eq("iow_rdata_held", bus_read_data, 8'hA5);
    idle_gap(3);

    // Memory write with n_wait low for 30 clocks across the T2 sample point
    run_cycle(1'b0, 1'b1, 1'b1, 16'hC000, 8'h5A, 8'h00, 32, 1'b0);
    $display("[TB] mem wr C000 wait: lat=%0d wr=%0d mereq=%0d", lat, c_wr, c_mereq);
    check_eq("mww_lat", lat, exp_wait_lat);
    check_eq("mww_wr", c_wr, exp_wait_wr);
    check_eq("mww_mereq", c_mereq, exp_wait_mreq);
    check_eq("mww_rden", c_rden, 0);
    idle_gap(3);

    // Simultaneous I/O and memory requests: I/O first, memory one IDLE clock later
    run_cycle(1'b1, 1'b1, 1'b0, 16'h0099, 8'h00, 8'h77, -1, 1'b1);
    $display("[TB] io+mem arb io: lat=%0d ioreq=%0d mereq=%0d data=%02h", lat, c_ioreq, c_mereq, bus_read_data);
    check_eq("arb_io_lat", lat, 96);
    check_eq("arb_io_ioreq", c_ioreq, 60);
    check_eq("arb_io_mereq", c_mereq, 0);
    check_eq("arb_io_data", bus_read_data, 8'h77);
    prev_ack = ack_cyc;
    run_cycle(1'b0, 1'b1, 1'b0, 16'h0099, 8'h00, 8'h66, -1, 1'b0);
    $display("[TB] io+mem arb mem: gap=%0d first=%0d mereq=%0d data=%02h", ack_cyc - prev_ack, first_low, c_mereq, bus_read_data);
    check_eq("arb_mem_gap", ack_cyc - prev_ack, 73);
    check_eq("arb_mem_first", first_low, 12);
    check_eq("arb_mem_mereq", c_mereq, 48);
    check_eq("arb_mem_data", bus_read_data, 8'h66);
    idle_gap(3);

    // Reset during T2 of a memory read
    bus_memory_req = 1'b1; bus_write = 1'b0; bus_address = 16'h8000; i_data = 8'h11;
    repeat (30) @(posedge clk);
    #1;
    check_eq("rab_rd_active", n_rd, 1'b0);
    n_reset = 1'b0;
    #1;
    $display("[TB] reset abort: strobes=%05b is_output=%0b adr=%04h", {n_sltsl, n_mereq, n_ioreq, n_rd, n_wr}, is_output, adr);
    check_eq("rab_strobes", {n_sltsl, n_mereq, n_ioreq, n_rd, n_wr}, 5'b11111);
    check_eq("rab_is_output", is_output, 1'b0);
    check_eq("rab_adr", adr, 16'h0000);
    bus_memory_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) n_reset = 1'b1;
    acks = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (bus_ack) acks++;
    end
    check_eq("rab_no_ack", acks, 0);
    run_cycle(1'b0, 1'b1, 1'b0, 16'h8000, 8'h00, 8'h3E, -1, 1'b0);
    $display("[TB] post-reset rd 8000: lat=%0d data=%02h", lat, bus_read_data);
    check_eq("rab_fresh_lat", lat, 72);
    check_eq("rab_fresh_data", bus_read_data, 8'h3E);
    idle_gap(3);

    // Ten back-to-back memory reads
    prev_ack = 0;
    for (int i = 0; i < 10; i++) begin
      run_cycle(1'b0, 1'b1, 1'b0, 16'(16'h4100 + i), 8'h00, 8'(8'h10 + i), -1, (i < 9));
      $display("[TB] b2b rd %04h: lat=%0d adr_t1=%04h data=%02h gap=%0d", 16'(16'h4100 + i), lat, adr_t1, bus_read_data, ack_cyc - prev_ack);
      check_eq("b2b_adr_t1", adr_t1, 16'(16'h4100 + i));
      check_eq("b2b_data", bus_read_data, 8'(8'h10 + i));
      check_eq("b2b_lat", lat, 72);
      if (i > 0) check_eq("b2b_gap", ack_cyc - prev_ack, 73);
      prev_ack = ack_cyc;
    end
    idle_gap(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ip_msxbus_master.md
# ip_msxbus_master

Initiator-side MSX50BUS engine: converts single-request internal bus transactions into Z80-timed MSX cartridge-slot bus cycles (memory and I/O, read and write) on the external connector. It sits between a host-side core (CPU clone or debugger) and the slot pins. It drives address, strobes and data, and samples read data and `n_wait` with cycle-accurate T-state sequencing derived from `clk`. It is the counterpart of `ip_msxbus`, which responds to such cycles.

## Interface
Parameters:
- `CLK_DIV`, 24: `clk` cycles per T-state (85.90908 MHz / 24 = 3.579545 MHz); even, ≥4.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `n_reset` in 1: reset, asynchronous, active-low.
- `bus_address` in 16: transaction address.
- `bus_write_data` in 8: write data.
- `bus_io_req` in 1: level request, I/O cycle; held until `bus_ack`.
- `bus_memory_req` in 1: level request, memory cycle; held until `bus_ack`.
- `bus_write` in 1: 1 = write, 0 = read; stable while a request is held.
- `bus_ack` out 1: one-cycle pulse, transaction complete.
- `bus_read_data` out 8: captured read data; held until the next read completes.
- `bus_read_data_en` out 1: one-cycle pulse coincident with `bus_ack` on reads only.
- `adr` out 16: slot address.
- `o_data` out 8: slot write data.
- `i_data` in 8: slot read data.
- `is_output` out 1: 1 = drive `o_data` onto the data bus.
- `n_sltsl`, `n_mereq`, `n_ioreq`, `n_rd`, `n_wr` out 1 each: active-low strobes.
- `n_wait` in 1: active-low wait from the slot (asynchronous).

## Operation
- States: IDLE, T1, T2, TW, T3. Divider `tcnt` counts 0..CLK_DIV-1 within each T-state. `h` = CLK_DIV/2.
- IDLE: if `bus_io_req` is 1, accept an I/O cycle. Else if `bus_memory_req` is 1, accept a memory cycle. If both are set, I/O wins. Latch address, data and direction. Move to T1 with `tcnt`=0.
- T1→T2 when `tcnt`=CLK_DIV-1.
- T2→T3 when `tcnt`=CLK_DIV-1, unless this is an I/O cycle or wait was sampled active, in which case T2→TW.
- TW repeats or exits to T3 as follows:
  - I/O: the first TW is mandatory.
  - Every TW: wait is sampled at `tcnt`=h. If active, another TW follows; otherwise T3 follows.
- T3→IDLE when `tcnt`=CLK_DIV-1. `bus_ack` pulses on that transition clock edge, so it is visible during the first IDLE cycle. No new request is accepted in that same cycle.
- Wait sampling: `n_wait` passes through a 2-flop synchronizer. It is sampled at T2 `tcnt`=h and at TW `tcnt`=h.
- Strobe windows (start edge inclusive, end edge exclusive):
  - Memory: `n_mereq`/`n_sltsl` low from T1+h to T3+h.
  - Memory read: `n_rd` low over the same window.
  - Memory write: `n_wr` low from T2+h to T3+h.
  - I/O: `n_ioreq` and `n_rd`/`n_wr` low from T2 start to T3+h. `n_sltsl` stays high.
- `is_output`: 1 from T1+h to T3 end, writes only.
- `o_data`: latched write data.
- `adr`: driven from T1 start and held afterwards, including in IDLE.
- Read capture: `i_data` is registered into `bus_read_data` at T3 `tcnt`=h.
- Dropping a request mid-cycle has no effect; the cycle completes.

## Timing
- Reset values:
  - All strobes = 1, `is_output`=0, `bus_ack`=0, `bus_read_data_en`=0.
  - `adr`=0, `o_data`=0, `bus_read_data`=0.
  - State = IDLE.
- Reset asserted mid-cycle aborts immediately to these values. There is no ack.
- Cycle length from the acceptance edge to `bus_ack`:
  - Memory: 3·CLK_DIV clocks (72).
  - I/O: 4·CLK_DIV clocks (96).
  - Each extra TW adds CLK_DIV clocks.
- Back-to-back requests: minimum 1 IDLE clock between cycles.
- `n_wait` held low indefinitely stalls in TW indefinitely. There is no timeout.

## Configuration
- `MSXBUS_MASTER_WAIT_EN` defined: synchronizer instantiated and wait honoured as described.
- Not defined: `n_wait` is ignored and the synchronizer is not built.
  - Memory cycles are always exactly 3 T-states.
  - I/O cycles are always exactly 4 T-states (single mandatory TW).

## Structure
- Shared include `msxbus_pkg`:
  - State encodings (IDLE/T1/T2/TW/T3).
  - Default `CLK_DIV`.
  - Strobe inactive-level constant.
- Sub-module `ip_msxbus_master_tstate`:
  - T-state divider.
  - Outputs `tcnt`, `t_last` (`tcnt`=CLK_DIV-1) and `t_half` (`tcnt`=h).
  - Restarted on cycle acceptance.

## Test plan
- Memory read at 0x4000, `i_data`=0xA5:
  - `n_mereq`/`n_rd` low for 48 clocks.
  - `bus_ack` and `bus_read_data_en` pulse at clock 72.
  - `bus_read_data`=0xA5.
- I/O write 0x98 ← 0x3C:
  - `n_ioreq`/`n_wr` low from clock 24 to 84.
  - `o_data`=0x3C while `is_output`=1.
  - `bus_ack` at clock 96; no `bus_read_data_en`.
- Memory write with `n_wait` low for 30 clocks spanning T2+h (macro on):
  - Exactly 2 TW inserted.
  - `bus_ack` at clock 120.
  - Same stimulus with the macro off: `bus_ack` at clock 72.
- Simultaneous `bus_io_req` and `bus_memory_req`:
  - I/O cycle runs first.
  - After its ack plus 1 IDLE clock, the memory cycle starts.
- `n_reset` asserted at T2 of a read:
  - All strobes high and `is_output`=0 in the same cycle.
  - No ack.
  - After release, a fresh request completes normally.
- Ten back-to-back memory reads to incrementing addresses:
  - Each `bus_ack` 73 clocks apart.
  - `adr` updates at each T1 start.
